alu_control_mc: RTL and testbench
=================================

ALU_CONTROL_MC -- requirements
Module: alu_control_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal: 8, 16, 32, 64).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block accepts request this cycle.
REQ-008 alu_op  input  2  main-decoder ALU opcode.
REQ-009 func_code  input  6  R-type funct field.
REQ-010 a, b  input  WIDTH each  operands.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  WIDTH  operation result.
REQ-014 zero  output  1  result == 0.
REQ-015 illegal  output  1  request decoded as unsupported.
REQ-016 alu_ctrl  output  4  decoded control code of the held request.

Function
REQ-017 Decode: alu_op 0 -> ADD (2); alu_op 1 -> SUB (6); alu_op 2 by func_code: 36 AND (0), 37 OR (1), 32 ADD (2), 34 SUB (6), 42 SLT (7), 39 NOR (12), 0 SLL (3), 2 SRL (4), 24 MULT (8).
REQ-018 alu_op 3 or unlisted func_code under alu_op 2 SHALL set alu_ctrl 15, illegal 1, result 0, zero 1.
REQ-019 ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-020 SLT compares a, b as signed two's complement; result 1 or 0 zero-extended.
REQ-021 SLL/SRL shift a by b[SHW-1:0], logical, zero fill; shift 0 returns a.
REQ-022 MULT returns low WIDTH bits of unsigned a*b, computed iteratively one bit per cycle (shift-add).
REQ-023 FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE).
REQ-024 IDLE: in_valid at edge k accepts request, latches operands and alu_ctrl; non-MULT -> DONE at edge k (out_valid high from k+1); MULT -> BUSY.
REQ-025 BUSY: internal counter runs WIDTH iterations; -> DONE at edge k+WIDTH (out_valid high from k+WIDTH+1).
REQ-026 DONE: result, zero, illegal, alu_ctrl held stable; out_valid && out_ready -> IDLE at that edge; no new request accepted in that same cycle.
REQ-027 out_valid = (state == DONE); outputs SHALL NOT change while out_valid high and out_ready low.
REQ-028 Input changes during BUSY or DONE SHALL have no effect.

Reset
REQ-029 rst_n low at an edge SHALL force IDLE, counter 0, result 0, zero 1, illegal 0, alu_ctrl 0, out_valid 0, from any state including mid-MULT; in-flight request discarded.
REQ-030 in_ready SHALL be 0 during cycles where rst_n is low, and 1 the cycle after reset release.

Configuration
REQ-031 Macro ALU_CONTROL_MC_MULT_EN defined: MULT (funct 24) supported per REQ-022/025.
REQ-032 Macro undefined: funct 24 decodes illegal per REQ-018, no BUSY state or multiplier logic; all legal ops complete via IDLE -> DONE.

Verification
REQ-033 WIDTH 32, alu_op 2, funct 32, a 5, b 7, out_ready 1 -> out_valid next cycle, result 12, alu_ctrl 2, zero 0.
REQ-034 alu_op 2, funct 42, a 0xFFFFFFFF, b 1 -> result 1; funct 34, a 3, b 3 -> result 0, zero 1, alu_ctrl 6.
REQ-035 MULT_EN defined, funct 24, a 0x10000, b 0x10001 -> in_ready 0 for 32 cycles, out_valid from cycle 33 after accept, result 0x10000.
REQ-036 funct 24 without MULT_EN, and alu_op 3 -> illegal 1, alu_ctrl 15, result 0, latency 1.
REQ-037 out_ready held 0 for 5 cycles in DONE with inputs toggling -> result/alu_ctrl stable, in_ready 0; out_ready 1 -> IDLE next edge.
REQ-038 rst_n low at MULT iteration 10 -> next cycle out_valid 0, result 0; after release, ADD 1+1 -> result 2.

Source files
------------

// File: rtl/alu_control_mc.sv
// alu_control_mc: ALU-control decoder feeding a handshaked ALU with IDLE/BUSY/DONE sequencing.
// Optional feature macro: ALU_CONTROL_MC_MULT_EN enables the iterative shift-add MULT (funct 24).
// Without it funct 24 decodes as illegal and no BUSY state or multiplier datapath exists.
module alu_control_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [3:0]       alu_ctrl
);

    localparam logic [3:0] CTRL_AND  = 4'd0;
    localparam logic [3:0] CTRL_OR   = 4'd1;
    localparam logic [3:0] CTRL_ADD  = 4'd2;
    localparam logic [3:0] CTRL_SLL  = 4'd3;
    localparam logic [3:0] CTRL_SRL  = 4'd4;
    localparam logic [3:0] CTRL_SUB  = 4'd6;
    localparam logic [3:0] CTRL_SLT  = 4'd7;
    localparam logic [3:0] CTRL_MULT = 4'd8;
    localparam logic [3:0] CTRL_NOR  = 4'd12;
    localparam logic [3:0] CTRL_ILL  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd1
`ifdef ALU_CONTROL_MC_MULT_EN
        ,
        ST_BUSY = 2'd2
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;
    logic [3:0]         alu_ctrl_q, alu_ctrl_d;
    logic               out_valid_q, out_valid_d;
    logic [3:0]         ctrl_c;
    logic [WIDTH-1:0]   res_c;

`ifdef ALU_CONTROL_MC_MULT_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
`endif

    // Decode alu_op/func_code of the presented request into the ALU control code
    always_comb begin
        ctrl_c = CTRL_ILL;
        case (alu_op)
            2'd0: ctrl_c = CTRL_ADD;
            2'd1: ctrl_c = CTRL_SUB;
            2'd2: begin
                case (func_code)
                    6'd36:   ctrl_c = CTRL_AND;
                    6'd37:   ctrl_c = CTRL_OR;
                    6'd32:   ctrl_c = CTRL_ADD;
                    6'd34:   ctrl_c = CTRL_SUB;
                    6'd42:   ctrl_c = CTRL_SLT;
                    6'd39:   ctrl_c = CTRL_NOR;
                    6'd0:    ctrl_c = CTRL_SLL;
                    6'd2:    ctrl_c = CTRL_SRL;
`ifdef ALU_CONTROL_MC_MULT_EN
                    6'd24:   ctrl_c = CTRL_MULT;
`endif
                    default: ctrl_c = CTRL_ILL;
                endcase
            end
            default: ctrl_c = CTRL_ILL;
        endcase
    end

    // Single-cycle ALU result; illegal and MULT produce 0 here
    always_comb begin
        res_c = '0;
        case (ctrl_c)
            CTRL_AND: res_c = a & b;
            CTRL_OR:  res_c = a | b;
            CTRL_ADD: res_c = a + b;
            CTRL_SUB: res_c = a - b;
            CTRL_SLT: res_c = WIDTH'($signed(a) < $signed(b));
            CTRL_NOR: res_c = ~(a | b);
            CTRL_SLL: res_c = a << b[SHW-1:0];
            CTRL_SRL: res_c = a >> b[SHW-1:0];
            default:  res_c = '0;
        endcase
    end

    // Next-state and held-output computation
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        illegal_d  = illegal_q;
        alu_ctrl_d = alu_ctrl_q;
`ifdef ALU_CONTROL_MC_MULT_EN
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    alu_ctrl_d = ctrl_c;
                    illegal_d  = (ctrl_c == CTRL_ILL);
                    result_d   = res_c;
                    state_d    = ST_DONE;
`ifdef ALU_CONTROL_MC_MULT_EN
                    if (ctrl_c == CTRL_MULT) begin
                        result_d = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        cnt_d    = '0;
                        state_d  = ST_BUSY;
                    end
`endif
                end
            end
`ifdef ALU_CONTROL_MC_MULT_EN
            ST_BUSY: begin
                if (mplier_q[0]) begin
                    result_d = result_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d      = (result_d == '0);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b1;
            illegal_q   <= 1'b0;
            alu_ctrl_q  <= 4'd0;
            out_valid_q <= 1'b0;
`ifdef ALU_CONTROL_MC_MULT_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            alu_ctrl_q  <= alu_ctrl_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_CONTROL_MC_MULT_EN
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign alu_ctrl  = alu_ctrl_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: directed and randomized checks of alu_control_mc against a behavioural model.
module tb_alu_control_mc;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   alu_op;
    logic [5:0]   func_code;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;
    logic [3:0]   alu_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_control_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .func_code (func_code),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .alu_ctrl  (alu_ctrl)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: what a single request must produce
    function automatic void model_op(input logic [1:0] op, input logic [5:0] fn,
                                     input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [3:0] c, output logic [W-1:0] r,
                                     output bit is_mult);
        logic [63:0] p;
        is_mult = 1'b0;
        c = 4'd15;
        r = '0;
        p = 64'(x) * 64'(y);
        if (op == 2'd0) begin
            c = 4'd2; r = x + y;
        end else if (op == 2'd1) begin
            c = 4'd6; r = x - y;
        end else if (op == 2'd2) begin
            case (fn)
                6'd36: begin c = 4'd0;  r = x & y; end
                6'd37: begin c = 4'd1;  r = x | y; end
                6'd32: begin c = 4'd2;  r = x + y; end
                6'd34: begin c = 4'd6;  r = x - y; end
                6'd42: begin c = 4'd7;  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; end
                6'd39: begin c = 4'd12; r = ~(x | y); end
                6'd0:  begin c = 4'd3;  r = x << (y % W); end
                6'd2:  begin c = 4'd4;  r = x >> (y % W); end
`ifdef ALU_CONTROL_MC_MULT_EN
                6'd24: begin c = 4'd8;  r = p[W-1:0]; is_mult = 1'b1; end
`endif
                default: begin c = 4'd15; r = '0; end
            endcase
        end
    endfunction

    // Model of the handshake timeline, advanced on each rising edge
    bit           m_live = 0;
    bit           m_busy = 0;
    bit           m_done = 0;
    int           m_wait = 0;
    logic [W-1:0] m_res  = '0;
    logic [3:0]   m_ctrl = '0;
    logic         m_ill  = 1'b0;

    always @(posedge clk) begin
        logic [3:0]   c;
        logic [W-1:0] r;
        bit           mu;
        if (!rst_n) begin
            m_live = 1; m_busy = 0; m_done = 0; m_wait = 0;
        end else if (m_done) begin
            if (out_ready) m_done = 0;
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin m_busy = 0; m_done = 1; end
        end else if (in_valid) begin
            model_op(alu_op, func_code, a, b, c, r, mu);
            m_res  = r;
            m_ctrl = c;
            m_ill  = (c == 4'd15);
            if (mu) begin m_busy = 1; m_wait = W; end
            else m_done = 1;
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        #1;
        if (m_live) begin
            check("in_ready", 64'(in_ready), 64'(rst_n && !m_busy && !m_done));
            check("out_valid", 64'(out_valid), 64'(m_done));
            if (m_done) begin
                check("result", 64'(result), 64'(m_res));
                check("zero", 64'(zero), 64'(m_res == '0));
                check("illegal", 64'(illegal), 64'(m_ill));
                check("alu_ctrl", 64'(alu_ctrl), 64'(m_ctrl));
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic z, output logic il,
                          output logic [3:0] c, output int lat);
        @(negedge clk);
        alu_op = op; func_code = fn; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r = result; z = zero; il = illegal; c = alu_ctrl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        logic         z;
        logic         il;
        logic [3:0]   c;
        int           lat;
        logic [5:0]   fns [10];
        fns = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd39, 6'd0, 6'd2, 6'd24, 6'd5};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'd0; func_code = 6'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_result", 64'(result), 64'h0);
        check("rst_zero", 64'(zero), 64'h1);
        check("rst_illegal", 64'(illegal), 64'h0);
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'h1);

        // Directed literal cases
        run_op(2'd2, 6'd32, 32'd5, 32'd7, r, z, il, c, lat);
        check("add_res", 64'(r), 64'd12); check("add_ctrl", 64'(c), 64'd2);
        check("add_zero", 64'(z), 64'd0); check("add_lat", 64'(lat), 64'd1);

        run_op(2'd2, 6'd42, 32'hFFFF_FFFF, 32'd1, r, z, il, c, lat);
        check("slt_res", 64'(r), 64'd1); check("slt_ctrl", 64'(c), 64'd7);

        run_op(2'd2, 6'd34, 32'd3, 32'd3, r, z, il, c, lat);
        check("sub_res", 64'(r), 64'd0); check("sub_zero", 64'(z), 64'd1);
        check("sub_ctrl", 64'(c), 64'd6);

        run_op(2'd2, 6'd0, 32'd1, 32'd36, r, z, il, c, lat);
        check("sll_res", 64'(r), 64'h10); check("sll_ctrl", 64'(c), 64'd3);

        run_op(2'd2, 6'd2, 32'h8000_0000, 32'd31, r, z, il, c, lat);
        check("srl_res", 64'(r), 64'h1); check("srl_ctrl", 64'(c), 64'd4);

        run_op(2'd2, 6'd2, 32'hDEAD_BEEF, 32'd64, r, z, il, c, lat);
        check("srl0_res", 64'(r), 64'hDEAD_BEEF);

        run_op(2'd2, 6'd39, 32'h0, 32'h0F, r, z, il, c, lat);
        check("nor_res", 64'(r), 64'hFFFF_FFF0); check("nor_ctrl", 64'(c), 64'd12);

        run_op(2'd1, 6'd0, 32'd0, 32'd1, r, z, il, c, lat);
        check("sub_wrap", 64'(r), 64'hFFFF_FFFF);

        run_op(2'd2, 6'd24, 32'h1_0000, 32'h1_0001, r, z, il, c, lat);
`ifdef ALU_CONTROL_MC_MULT_EN
        check("mult_res", 64'(r), 64'h1_0000); check("mult_ctrl", 64'(c), 64'd8);
        check("mult_ill", 64'(il), 64'd0); check("mult_lat", 64'(lat), 64'd33);
`else
        check("mult_off_res", 64'(r), 64'd0); check("mult_off_ctrl", 64'(c), 64'd15);
        check("mult_off_ill", 64'(il), 64'd1); check("mult_off_lat", 64'(lat), 64'd1);
`endif

        run_op(2'd3, 6'd32, 32'd9, 32'd9, r, z, il, c, lat);
        check("op3_res", 64'(r), 64'd0); check("op3_zero", 64'(z), 64'd1);
        check("op3_ctrl", 64'(c), 64'd15); check("op3_ill", 64'(il), 64'd1);
        check("op3_lat", 64'(lat), 64'd1);

        // Back-pressure in DONE with toggling inputs
        @(negedge clk);
        out_ready = 1'b0;
        alu_op = 2'd0; a = 32'd9; b = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_res", 64'(result), 64'd10);
            check("hold_ctrl", 64'(alu_ctrl), 64'd2);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'b1; alu_op = 2'($urandom); func_code = 6'($urandom);
            a = $urandom; b = $urandom;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_idle_valid", 64'(out_valid), 64'd0);
        check("release_idle_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;

        // Reset in the middle of a (possibly multi-cycle) request
        @(negedge clk);
        out_ready = 1'b0;
        alu_op = 2'd2; func_code = 6'd24; a = 32'h1234_5678; b = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_res", 64'(result), 64'd0);
        check("midrst_zero", 64'(zero), 64'd1);
        check("midrst_ctrl", 64'(alu_ctrl), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        run_op(2'd0, 6'd0, 32'd1, 32'd1, r, z, il, c, lat);
        check("post_rst_add", 64'(r), 64'd2); check("post_rst_lat", 64'(lat), 64'd1);

        // Randomized traffic with occasional resets and back-pressure
        repeat (600) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 63) != 0);
            in_valid  = ($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            alu_op    = 2'($urandom_range(0, 3));
            func_code = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 9)];
            a         = $urandom;
            b         = ($urandom_range(0, 3) == 0) ? a : $urandom;
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
